// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic array sequencer.
package systolic_pkg;

  localparam int N_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    OUT
  } state_t;

  // Bits needed for the cycle counter to reach the longest RUN phase minus one.
  function automatic int cnt_width(input int k_max, input int lat, input int n);
    return $clog2(k_max + lat + 2 * (n - 1));
  endfunction

  function automatic int run_len(input int k, input int lat, input int n);
    return k + lat + 2 * (n - 1);
  endfunction

endpackage

// File: rtl/systolic_win_gen.sv
// Window decoder: maps the RUN cycle index and job length K to per-PE
// accumulate-valid and first-beat clear, following the row+column skew.
module systolic_win_gen
  import systolic_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int K_MAX = 64,
  parameter int LAT   = 1,
  parameter int CW    = cnt_width(K_MAX, LAT, N),
  parameter int KW    = $clog2(K_MAX + 1)
) (
  input  logic [CW-1:0]  c,
  input  logic [KW-1:0]  k,
  output logic [N*N-1:0] valid,
  output logic [N*N-1:0] clear
);

  always_comb begin
    valid = '0;
    clear = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        // Operand k reaches PE(i,j) at cycle k + LAT + i + j.
        valid[i*N+j] = (int'(c) >= LAT + i + j) && (int'(c) < LAT + i + j + int'(k));
        clear[i*N+j] = (int'(c) == LAT + i + j);
      end
    end
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Job sequencer for the N x N systolic MAC array: operand feed, PE valid/clear
// windows, result readout and row handoff. All outputs come straight from flops.
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int K_MAX = 64,
  parameter int LAT   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [$clog2(K_MAX+1)-1:0] k_len,
  input  logic                       abort,
  output logic                       busy,
  output logic                       err,
  output logic                       job_done,
  output logic                       feed_en,
  output logic [$clog2(K_MAX)-1:0]   feed_k,
  output logic [N*N-1:0]             pe_valid,
  output logic [N*N-1:0]             pe_clear,
  output logic                       pe_done,
  output logic [$clog2(N)-1:0]       row_sel,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int KW  = $clog2(K_MAX + 1);
  localparam int FKW = $clog2(K_MAX);
  localparam int RW  = $clog2(N);
  localparam int CW  = cnt_width(K_MAX, LAT, N);

  state_t        state, state_nxt;
  logic [CW-1:0] c, c_nxt, c_last;
  logic [KW-1:0] k, k_nxt;
  logic [RW-1:0] r, r_nxt;
  logic          err_nxt, done_nxt;

  logic           busy_nxt, feed_en_nxt, pe_done_nxt, out_valid_nxt;
  logic [FKW-1:0] feed_k_nxt;
  logic [N*N-1:0] win_valid, win_clear, pe_valid_nxt, pe_clear_nxt;
  logic [RW-1:0]  row_sel_nxt;

  assign c_last = CW'(run_len(int'(k), LAT, N) - 1);

  always_comb begin
    state_nxt = state;
    c_nxt     = c;
    k_nxt     = k;
    r_nxt     = r;
    err_nxt   = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        // abort in the same cycle drops the request entirely, including err
        if (start && !abort) begin
          if (k_len != '0 && int'(k_len) <= K_MAX) begin
            state_nxt = RUN;
            k_nxt     = k_len;
            c_nxt     = '0;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (c == c_last) begin
          state_nxt = OUT;
          r_nxt     = '0;
        end else begin
          c_nxt = c + 1'b1;
        end
      end
      OUT: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (out_valid && out_ready) begin
          if (int'(r) == N - 1) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            r_nxt = r + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Windows are decoded from the next counter value so the registered
  // outputs line up with the cycle the counter describes.
  systolic_win_gen #(
    .N    (N),
    .K_MAX(K_MAX),
    .LAT  (LAT),
    .CW   (CW),
    .KW   (KW)
  ) u_win_gen (
    .c    (c_nxt),
    .k    (k_nxt),
    .valid(win_valid),
    .clear(win_clear)
  );

  always_comb begin
    busy_nxt      = (state_nxt != IDLE);
    feed_en_nxt   = (state_nxt == RUN) && (int'(c_nxt) < int'(k_nxt));
    feed_k_nxt    = feed_en_nxt ? c_nxt[FKW-1:0] : '0;
    pe_valid_nxt  = (state_nxt == RUN) ? win_valid : '0;
    pe_clear_nxt  = (state_nxt == RUN) ? win_clear : '0;
    pe_done_nxt   = (state_nxt == OUT);
    out_valid_nxt = (state_nxt == OUT);
    row_sel_nxt   = (state_nxt == OUT) ? r_nxt : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      c         <= '0;
      k         <= '0;
      r         <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
      job_done  <= 1'b0;
      feed_en   <= 1'b0;
      feed_k    <= '0;
      pe_valid  <= '0;
      pe_clear  <= '0;
      pe_done   <= 1'b0;
      row_sel   <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      c         <= c_nxt;
      k         <= k_nxt;
      r         <= r_nxt;
      busy      <= busy_nxt;
      err       <= err_nxt;
      job_done  <= done_nxt;
      feed_en   <= feed_en_nxt;
      feed_k    <= feed_k_nxt;
      pe_valid  <= pe_valid_nxt;
      pe_clear  <= pe_clear_nxt;
      pe_done   <= pe_done_nxt;
      row_sel   <= row_sel_nxt;
      out_valid <= out_valid_nxt;
    end
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl: every cycle's outputs are compared with
// a model that tracks operand arrival times and the readout handshake.
module tb_systolic_ctrl;
  localparam int N = 4;
  localparam int K_MAX = 64;
  localparam int LAT = 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [6:0]     k_len = '0;
  logic           abort = 1'b0;
  logic           out_ready = 1'b0;
  logic           busy, err, job_done, feed_en, pe_done, out_valid;
  logic [5:0]     feed_k;
  logic [N*N-1:0] pe_valid, pe_clear;
  logic [1:0]     row_sel;
  logic [45:0]    obs;

  int errors = 0;
  int checks = 0;

  systolic_ctrl #(.N(N), .K_MAX(K_MAX), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .abort(abort),
    .busy(busy), .err(err), .job_done(job_done), .feed_en(feed_en),
    .feed_k(feed_k), .pe_valid(pe_valid), .pe_clear(pe_clear),
    .pe_done(pe_done), .row_sel(row_sel), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  assign obs = {busy, err, job_done, feed_en, feed_k, pe_valid, pe_clear,
                pe_done, out_valid, row_sel};

  // bp: 0 = ready always, 1 = random ready, 2 = ready low 3 cycles on row 2.
  // abort_at: cycle index after start at which abort is raised (-1 = never).
  // noise: toggle start/k_len randomly while busy; must be ignored.
  task automatic run_job(input string name, input int kk, input int abort_at,
                         input int bp, input bit noise, output int cyc);
    int lrun = kk + LAT + 2 * (N - 1);
    int r = 0;
    int hold = 0;
    bit aborted = 0;
    bit fin = 0;
    bit rdy;
    logic [45:0]    exp;
    logic [N*N-1:0] ev, ec;
    cyc = -1;
    @(negedge clk);
    start = 1'b1;
    k_len = 7'(kk);
    abort = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < lrun + 300 && !fin; t++) begin
      exp = '0;
      if (aborted) begin
        fin = 1;
      end else if (t < lrun) begin
        ev = '0;
        ec = '0;
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            for (int kx = 0; kx < kk; kx++)
              if (kx + LAT + i + j == t) begin
                ev[i*N+j] = 1'b1;
                if (kx == 0) ec[i*N+j] = 1'b1;
              end
        exp = {1'b1, 1'b0, 1'b0, (t < kk), (t < kk) ? 6'(t) : 6'd0, ev, ec,
               1'b0, 1'b0, 2'd0};
      end else if (r == N) begin
        exp = {3'b001, 43'd0};
        fin = 1;
        cyc = t;
      end else begin
        exp = {1'b1, 1'b0, 1'b0, 1'b0, 6'd0, {(N*N){1'b0}}, {(N*N){1'b0}},
               1'b1, 1'b1, 2'(r)};
      end
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s t=%0d: got %h expected %h", name, t, obs, exp);
      end
      start = 1'b0;
      abort = 1'b0;
      out_ready = 1'b0;
      if (!fin) begin
        abort = (t == abort_at);
        if (t >= lrun) begin
          if (bp == 1) rdy = 1'($urandom_range(0, 1));
          else if (bp == 2 && r == 2 && hold < 3) begin
            rdy = 1'b0;
            hold++;
          end else rdy = 1'b1;
          out_ready = rdy;
          if (rdy && !abort) r++;
        end
        if (noise && t < lrun) begin
          start = 1'($urandom_range(0, 1));
          k_len = 7'($urandom_range(0, 127));
        end
        if (abort) aborted = 1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL %s timeout: job never returned to idle, obs %h", name, obs);
    end else if (obs !== 46'd0) begin
      errors++;
      $display("FAIL %s idle after job: got %h expected 0", name, obs);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== 46'd0) begin
      errors++;
      $display("FAIL reset_hold: got %h expected 0", obs);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== 46'd0) begin
      errors++;
      $display("FAIL reset_release: got %h expected 0", obs);
    end
  endtask

  task automatic test_nominal();
    int cyc;
    run_job("nominal", 4, -1, 0, 0, cyc);
    checks++;
    if (cyc != 15) begin
      errors++;
      $display("FAIL nominal_len: got %0d cycles expected 15", cyc);
    end
  endtask

  task automatic test_back_pressure();
    int cyc;
    run_job("back_pressure", 4, -1, 2, 0, cyc);
    checks++;
    if (cyc != 18) begin
      errors++;
      $display("FAIL back_pressure_len: got %0d cycles expected 18", cyc);
    end
  endtask

  task automatic test_illegal();
    int ks[4] = '{0, 65, 127, 100};
    foreach (ks[n]) begin
      @(negedge clk);
      start = 1'b1;
      k_len = 7'(ks[n]);
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (obs !== {1'b0, 1'b1, 44'd0}) begin
        errors++;
        $display("FAIL illegal_err k=%0d: got %h expected %h", ks[n], obs, {1'b0, 1'b1, 44'd0});
      end
      @(negedge clk);
      checks++;
      if (obs !== 46'd0) begin
        errors++;
        $display("FAIL illegal_after k=%0d: got %h expected 0", ks[n], obs);
      end
    end
  endtask

  task automatic test_abort_start_idle();
    int ks[2] = '{4, 0};
    foreach (ks[n]) begin
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      k_len = 7'(ks[n]);
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      checks++;
      if (obs !== 46'd0) begin
        errors++;
        $display("FAIL abort_start_idle k=%0d: got %h expected 0", ks[n], obs);
      end
    end
  endtask

  task automatic test_k1();
    int cyc;
    run_job("k1", 1, -1, 0, 0, cyc);
    checks++;
    if (cyc != 12) begin
      errors++;
      $display("FAIL k1_len: got %0d cycles expected 12", cyc);
    end
  endtask

  task automatic test_abort();
    int cyc;
    run_job("abort_run", 4, 5, 0, 0, cyc);
    run_job("abort_out", 4, 12, 0, 0, cyc);
    run_job("after_abort", 4, -1, 0, 0, cyc);
    checks++;
    if (cyc != 15) begin
      errors++;
      $display("FAIL after_abort_len: got %0d cycles expected 15", cyc);
    end
  endtask

  task automatic test_async_reset();
    int cyc;
    @(negedge clk);
    start = 1'b1;
    k_len = 7'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (obs !== 46'd0) begin
      errors++;
      $display("FAIL async_reset: got %h expected 0", obs);
    end
    @(negedge clk);
    rst = 1'b0;
    run_job("post_reset", 4, -1, 0, 0, cyc);
    checks++;
    if (cyc != 15) begin
      errors++;
      $display("FAIL post_reset_len: got %0d cycles expected 15", cyc);
    end
  endtask

  task automatic test_random();
    int cyc, kk, ab;
    for (int n = 0; n < 25; n++) begin
      kk = $urandom_range(1, K_MAX);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, kk + 10) : -1;
      run_job("random", kk, ab, 1, 1'($urandom_range(0, 1)), cyc);
    end
    run_job("k_max", K_MAX, -1, 1, 1, cyc);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_back_pressure();
    test_illegal();
    test_abort_start_idle();
    test_k1();
    test_abort();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/systolic_ctrl.md
Name: systolic_ctrl

Overview:
- Sequencer for the N x N systolic array of MAC processing elements.
- On a start request it does four things in order:
  - streams the inner dimension K out of the operand buffers;
  - drives each PE's accumulate-valid and clear window, matched to the row/column skew;
  - holds the PEs' done flag during result readout;
  - hands the N result rows to the downstream writer over a valid/ready handshake.
- Sits between the host command interface and the PE array plus its skew feeder.

Parameters:
- N, 4, array dimension (rows = columns).
- K_MAX, 64, maximum inner dimension per job.
- LAT, 1, cycles from feed_en/feed_k to operand arrival at PE(0,0); covers buffer read latency and the first skew stage.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  job request; sampled only in IDLE
- k_len  in  clog2(K_MAX+1)  inner dimension for the job; legal range 1..K_MAX
- abort  in  1  synchronous job cancel
- busy  out  1  high in any state other than IDLE
- err  out  1  one-cycle pulse when start is rejected
- job_done  out  1  one-cycle pulse after the last result row is accepted
- feed_en  out  1  operand buffers read A column k / B row k this cycle
- feed_k  out  clog2(K_MAX)  k index for the read
- pe_valid  out  N*N  per-PE valid_i, bit i*N+j maps to PE(i,j)
- pe_clear  out  N*N  per-PE clear, asserted only on that PE's first valid beat
- pe_done  out  1  broadcast done to all PEs; enables saturated acc_o
- row_sel  out  clog2(N)  result row presented to the writer
- out_valid  out  1  result row valid
- out_ready  in  1  writer accepts the row

Behaviour:
- Reset value of every output is 0; the state register resets to IDLE.
- Asserting rst mid-job forces IDLE immediately, with no job_done and no err.
- All outputs are registered.
- States:
  - IDLE -> RUN: on start with 1 <= k_len <= K_MAX. k_len is latched as K and the cycle counter c is cleared to 0.
  - Start rejection: start with k_len == 0 or k_len > K_MAX pulses err for 1 cycle and stays in IDLE.
  - start while busy is ignored.
- RUN, with c = cycles since RUN entry (0-based):
  - feed_en = 1 and feed_k = c for 0 <= c < K; otherwise 0.
  - pe_valid[i*N+j] = 1 iff LAT+i+j <= c < LAT+i+j+K.
  - pe_clear[i*N+j] = 1 iff c == LAT+i+j.
  - RUN lasts L = K+LAT+2(N-1) cycles. In cycle c = L-1, go to OUT with r = 0.
- OUT:
  - pe_done = 1, out_valid = 1, row_sel = r.
  - On out_valid && out_ready: r increments.
  - If r == N-1 when the handshake fires: the next cycle enters IDLE, pe_done and out_valid deassert, and job_done pulses for 1 cycle.
  - out_valid stays high and row_sel stays stable until accepted; there is no timeout.
- pe_done is 0 in IDLE and RUN, so PE outputs read as 0 during compute.
- abort in RUN or OUT: the next cycle is IDLE with all outputs 0 and no job_done. PE accumulators are not cleared; the next job's pe_clear handles that.
- abort with start in IDLE: abort wins and the start is dropped.
- K = 1 is legal: every PE sees exactly one beat, with valid and clear in the same cycle.
- Counter widths must hold K_MAX+LAT+2(N-1)-1 without wrap.

Decomposition:
- Shared package systolic_pkg holds:
  - state enum IDLE/RUN/OUT;
  - constant functions for the counter width and RUN length;
  - the N default shared with the array top.
- One sub-module, systolic_win_gen: combinational window decoder mapping (c, K) to pe_valid/pe_clear. It is instantiated once, and its output is registered in systolic_ctrl.

Test Plan:
- Nominal job (N=4, LAT=1, K=4, out_ready tied 1):
  - feed_en for c = 0..3;
  - PE(0,0) valid c = 1..4 with clear at c = 1;
  - PE(3,3) valid c = 7..10 with clear at c = 7;
  - RUN lasts 11 cycles, then row_sel 0,1,2,3 on consecutive cycles;
  - job_done pulses 1 cycle after row 3;
  - total 15 cycles from start to IDLE.
- Back-pressure: out_ready low for 3 cycles on row 2 -> row_sel holds 2, out_valid and pe_done stay high, then rows proceed.
- Illegal k_len = 0 and k_len = 65 -> err pulse each time, busy stays 0, no feed_en.
- K = 1 -> each PE has a single cycle with valid and clear together; RUN lasts 8 cycles.
- abort at c = 5 and abort during OUT row 1 -> next cycle IDLE, all outputs 0, no job_done; a following start with K = 4 matches the nominal trace.
- rst asserted asynchronously mid-RUN -> outputs 0 without waiting for a clock edge; start after release runs the nominal trace.
